// File: rtl/counter_ctrl.sv
// Pushbutton front end plus run/pause/done controller that drives an external
// WIDTH-bit counter through registered one-cycle strobes.

module key_db #(
    parameter int DB_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync;
    logic [1:0]    vld_pipe;
    logic          db_lvl;
    logic          armed;
    logic [CW-1:0] db_cnt;
    logic          flip;

    assign flip = (sync[1] != db_lvl) && (db_cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync     <= 2'b11;
            vld_pipe <= '0;
            db_lvl   <= 1'b1;
            armed    <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            sync     <= {sync[0], key_n};
            vld_pipe <= {vld_pipe[0], 1'b1};
            // A key held through reset stays disarmed until a real release is sampled.
            armed    <= armed | (vld_pipe[1] & sync[1]);
            press    <= flip & ~sync[1] & armed;
            if (sync[1] == db_lvl) begin
                db_cnt <= '0;
            end else if (flip) begin
                db_cnt <= '0;
                db_lvl <= sync[1];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
endmodule

module counter_ctrl #(
    parameter int WIDTH     = 8,
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [2:0]       KEY,
    input  logic [WIDTH-1:0] SW,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             cnt_ld,
    output logic [WIDTH-1:0] cnt_d,
    output logic [1:0]       state,
    output logic             done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

    state_t        st_q, st_d;
    logic [2:0]    press;
    logic          start_ev, clr_ev, ld_ev, tick;
    logic [PW-1:0] presc_q, presc_d;
    logic          en_d, clr_d, ld_d;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_key
            key_db #(.DB_CYCLES(DB_CYCLES)) u_db (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .key_n    (KEY[i]),
                .press    (press[i])
            );
        end
    endgenerate

    assign start_ev = press[0];
    assign clr_ev   = press[1];
    assign ld_ev    = press[2];
    assign tick     = (st_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
    assign state    = st_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            st_q    <= IDLE;
            presc_q <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            cnt_ld  <= 1'b0;
            cnt_d   <= '0;
            done    <= 1'b0;
        end else begin
            st_q    <= st_d;
            presc_q <= presc_d;
            cnt_en  <= en_d;
            cnt_clr <= clr_d;
            cnt_ld  <= ld_d;
            done    <= (st_d == DONE);
            if (ld_d) cnt_d <= SW;
        end
    end

    always_comb begin
        st_d = st_q;
        if (clr_ev) begin
            st_d = IDLE;
        end else if (start_ev) begin
            case (st_q)
                IDLE:    st_d = RUN;
                RUN:     st_d = PAUSE;
                PAUSE:   st_d = RUN;
                DONE:    st_d = IDLE;
                default: st_d = IDLE;
            endcase
        end else if (tick && (cnt_q == '1)) begin
            st_d = DONE;
        end
    end

    // Priority clear > start > load/tick: lower events in a higher event's cycle are dropped.
    always_comb begin
        clr_d = clr_ev;
        ld_d  = ~clr_ev & ~start_ev & ld_ev & ((st_q == IDLE) || (st_q == PAUSE));
        en_d  = ~clr_ev & ~start_ev & tick & (cnt_q != '1);
        if (clr_ev || (st_q == IDLE) || (st_q == DONE))
            presc_d = '0;
        else if (st_q == RUN)
            presc_d = tick ? '0 : presc_q + 1'b1;
        else
            presc_d = presc_q;
    end
endmodule

// File: tb/tb_counter_ctrl.sv
// Random and directed key stimulus checked each cycle against a behavioural model.

module tb_counter_ctrl;
    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 5;
    localparam int DB       = 4;
    localparam int HL       = DB + 2;

    logic             CLOCK_50 = 1'b0;
    logic             reset;
    logic [2:0]       KEY;
    logic [WIDTH-1:0] SW, cnt_q, cnt_d;
    logic             cnt_en, cnt_clr, cnt_ld, done;
    logic [1:0]       state;

    counter_ctrl #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .DB_CYCLES(DB)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .KEY      (KEY),
        .SW       (SW),
        .cnt_q    (cnt_q),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .cnt_ld   (cnt_ld),
        .cnt_d    (cnt_d),
        .state    (state),
        .done     (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Behavioural model: state as 0..3, keys judged over a sample window.
    int         m_st = 0, m_presc = 0, m_d = 0;
    bit         m_en = 0, m_clr = 0, m_ld = 0;
    bit [2:0]   ev = '0, db_lvl = 3'b111, armed = '0;
    logic [2:0] hist [HL];
    int         n_smp = 0;

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_st = 0; m_presc = 0; m_d = 0;
            m_en = 0; m_clr = 0; m_ld = 0;
            ev = '0; db_lvl = 3'b111; armed = '0; n_smp = 0;
        end else begin
            bit       tk;
            bit       flip;
            bit [2:0] nev;
            tk = (m_st == 1) && (m_presc == TICK_DIV - 1);
            m_en = 0; m_clr = 0; m_ld = 0;
            if (ev[1]) begin
                m_st = 0; m_clr = 1; m_presc = 0;
            end else if (ev[0]) begin
                if (m_st == 1) m_presc = (m_presc + 1) % TICK_DIV;
                m_st = (m_st == 0) ? 1 : (m_st == 1) ? 2 : (m_st == 2) ? 1 : 0;
            end else if (ev[2] && (m_st == 0 || m_st == 2)) begin
                m_ld = 1; m_d = int'(SW);
            end else if (m_st == 1) begin
                m_presc = (m_presc + 1) % TICK_DIV;
                if (tk) begin
                    if (cnt_q == 4'hF) m_st = 3;
                    else m_en = 1;
                end
            end
            // hist[j] = KEY sampled j edges ago; synchronized level is two edges old.
            for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = KEY;
            if (n_smp < HL) n_smp++;
            for (int k = 0; k < 3; k++) begin
                flip = (n_smp == HL);
                for (int j = 2; j < HL; j++) if (hist[j][k] == db_lvl[k]) flip = 0;
                nev[k] = 0;
                if (flip) begin
                    db_lvl[k] = ~db_lvl[k];
                    nev[k] = !db_lvl[k] && armed[k];
                end
                if (n_smp >= 3 && hist[2][k]) armed[k] = 1;
            end
            ev = nev;
        end
    end

    int               cyc_n = 0, last_en = -1, t_resume = -1;
    int               n_clr = 0, n_ld = 0, n_excl = 0, n_pause_en = 0;
    bit               gap_on = 0, res_on = 0, res_seen = 0;
    logic [1:0]       prev_state = 2'd0;
    logic [WIDTH-1:0] plant = '0;

    task automatic cyc();
        @(negedge CLOCK_50);
        cyc_n++;
        chk("state", 32'(state), 32'(m_st));
        chk("done", 32'(done), 32'(m_st == 3));
        chk("cnt_en", 32'(cnt_en), 32'(m_en));
        chk("cnt_clr", 32'(cnt_clr), 32'(m_clr));
        chk("cnt_ld", 32'(cnt_ld), 32'(m_ld));
        chk("cnt_d", 32'(cnt_d), 32'(m_d));
        if (int'(cnt_en) + int'(cnt_clr) + int'(cnt_ld) > 1) n_excl++;
        if (state == 2'd2 && cnt_en) n_pause_en++;
        n_clr += int'(cnt_clr);
        n_ld  += int'(cnt_ld);
        if (state != 2'd1) t_resume = -1;
        if (res_on && state == 2'd1 && prev_state == 2'd2) t_resume = cyc_n;
        if (cnt_en) begin
            if (gap_on && last_en >= 0) chk("en_gap", 32'(cyc_n - last_en), TICK_DIV);
            if (t_resume >= 0) begin
                chk("resume_gap", 32'(cyc_n - t_resume), 2);
                res_seen = 1;
                t_resume = -1;
            end
            last_en = cyc_n;
        end
        prev_state = state;
        if (m_clr) plant = '0;
        else if (m_ld) plant = WIDTH'(m_d);
        else if (m_en) plant = plant + 1'b1;
        cnt_q = plant;
    endtask

    task automatic press(input int k, input int hold, input int after);
        KEY[k] = 1'b0;
        repeat (hold) cyc();
        KEY[k] = 1'b1;
        repeat (after) cyc();
    endtask

    int ld0, clr0;

    initial begin
        KEY = 3'b111; SW = '0; cnt_q = '0; reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (3) cyc();

        press(0, 3, 15);
        chk("glitch_idle", 32'(state), 0);

        gap_on = 1; last_en = -1;
        press(0, 20, 20);
        gap_on = 0;
        chk("run", 32'(state), 1);

        // Key goes low with prescaler at 1 so its event lands at prescaler 2.
        for (int i = 0; i < 2 * TICK_DIV && m_presc != 1; i++) cyc();
        press(0, 6, 0);
        repeat (50) cyc();
        chk("paused", 32'(state), 2);
        res_on = 1;
        press(0, 6, 20);
        res_on = 0;
        chk("resumed", 32'(state), 1);
        chk("resume_seen", 32'(res_seen), 1);

        press(0, 6, 10);
        SW = 4'hA; ld0 = n_ld;
        press(2, 6, 10);
        chk("ld_pulse", 32'(n_ld - ld0), 1);
        chk("ld_data", 32'(cnt_d), 32'hA);
        chk("ld_state", 32'(state), 2);
        press(0, 6, 5);
        SW = 4'h5; ld0 = n_ld;
        press(2, 6, 10);
        chk("ld_run_ignored", 32'(n_ld - ld0), 0);
        chk("ld_hold", 32'(cnt_d), 32'hA);

        clr0 = n_clr;
        press(1, 6, 5);
        chk("clr_pulse", 32'(n_clr - clr0), 1);
        chk("clr_idle", 32'(state), 0);
        SW = 4'hE;
        press(2, 6, 5);
        press(0, 6, 0);
        for (int i = 0; i < 60 && state != 2'd3; i++) cyc();
        chk("done_state", 32'(state), 3);
        chk("done_flag", 32'(done), 1);
        clr0 = n_clr;
        press(1, 6, 5);
        chk("done_clr", 32'(n_clr - clr0), 1);
        chk("done_idle", 32'(state), 0);

        press(0, 6, 5);
        clr0 = n_clr;
        KEY = 3'b100;
        repeat (6) cyc();
        KEY = 3'b111;
        repeat (5) cyc();
        chk("both_clr", 32'(n_clr - clr0), 1);
        chk("both_idle", 32'(state), 0);

        press(0, 6, 5);
        KEY[0] = 1'b0;
        cyc();
        @(posedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_en", 32'(cnt_en), 0);
        chk("rst_clr", 32'(cnt_clr), 0);
        chk("rst_ld", 32'(cnt_ld), 0);
        chk("rst_d", 32'(cnt_d), 0);
        repeat (2) cyc();
        reset = 1'b0;
        repeat (20) cyc();
        chk("held_idle", 32'(state), 0);
        KEY = 3'b111;
        repeat (8) cyc();
        press(0, 6, 5);
        chk("rearm_run", 32'(state), 1);

        for (int i = 0; i < 150; i++) begin
            SW = WIDTH'($urandom);
            if ($urandom_range(0, 4) == 0) plant = 4'hF;
            KEY = 3'($urandom_range(0, 7)) | (($urandom_range(0, 2) != 0) ? 3'b010 : 3'b000);
            repeat ($urandom_range(1, 9)) cyc();
            KEY = 3'b111;
            repeat ($urandom_range(1, 12)) cyc();
        end

        chk("strobe_excl", 32'(n_excl), 0);
        chk("pause_no_en", 32'(n_pause_en), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
